// File: rtl/fib_pkg.sv
// Shared definitions for the recursive Fibonacci controller: state encoding,
// operand width and the packed stack-frame layout.
package fib_pkg;

  localparam int unsigned N_W = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALL = 3'd1,
    S_SUB1 = 3'd2,
    S_SUB2 = 3'd3,
    S_RET  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Frame = {acc, phase, n}; n and phase sit low so their offsets do not move with RES_W.
  localparam int unsigned N_LSB   = 0;
  localparam int unsigned PH_BIT  = N_W;
  localparam int unsigned ACC_LSB = N_W + 1;

  function automatic int unsigned frame_w(input int unsigned res_w);
    return ACC_LSB + res_w;
  endfunction

endpackage

// File: rtl/fib_stack.sv
// LIFO of recursion frames. Push/pop move the stack pointer; wr_top rewrites the
// top frame in place; clr discards every frame at the start of a new computation.
module fib_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned FW    = 12,
  parameter int unsigned SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic            wr_top,
  input  logic [FW-1:0]   din,
  output logic [FW-1:0]   top,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FW-1:0]    mem [DEPTH];
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;

  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign wr_idx  = push ? IDX_W'(sp) : top_idx;
  assign top     = mem[top_idx];
  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + SP_W'(1);
    end else if (pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Frame storage needs no reset: nothing is read below the stack pointer.
  always_ff @(posedge clk) begin
    if (push || wr_top) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/fib_controller.sv
// Recursive fib(n) sequencer: walks an explicit frame stack, drives the external
// shared subtractor for n-1 / n-2, and sums partial results with a local adder.
module fib_controller
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned RES_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       n_in,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             err,
  output logic [2:0]       sub_a,
  output logic [2:0]       sub_b,
  input  logic [2:0]       sub_s
);

  localparam int unsigned FW   = frame_w(RES_W);
  localparam int unsigned SP_W = $clog2(DEPTH + 1);

  state_t           state;
  logic [N_W-1:0]   cur_n;
  logic [RES_W-1:0] ret_val;
  logic [RES_W-1:0] sum;

  logic             clr, push, pop, wr_top, full, empty;
  logic [FW-1:0]    din, top_f;
  logic [SP_W-1:0]  sp;
  logic [N_W-1:0]   top_n;
  logic             top_ph;
  logic [RES_W-1:0] top_acc;

  assign top_n   = top_f[N_LSB +: N_W];
  assign top_ph  = top_f[PH_BIT];
  assign top_acc = top_f[ACC_LSB +: RES_W];
  assign sum     = top_acc + ret_val;

  always_comb begin
    clr    = (state == S_IDLE) && start;
    push   = (state == S_CALL) && (cur_n >= N_W'(2)) && !full;
    wr_top = (state == S_RET) && !empty && !top_ph;
    pop    = (state == S_RET) && !empty && top_ph;
    din    = '0;
    if (push) begin
      din[N_LSB +: N_W] = cur_n;
    end else begin
      din[N_LSB +: N_W]     = top_n;
      din[PH_BIT]           = 1'b1;
      din[ACC_LSB +: RES_W] = ret_val;
    end
  end

  fib_stack #(
    .DEPTH (DEPTH),
    .FW    (FW),
    .SP_W  (SP_W)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .push   (push),
    .pop    (pop),
    .wr_top (wr_top),
    .din    (din),
    .top    (top_f),
    .sp     (sp),
    .full   (full),
    .empty  (empty)
  );

  // sub_a/sub_b are registered, so they are loaded on entry to SUB1/SUB2 and
  // the subtractor result is valid for capture throughout that SUB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      sub_a   <= '0;
      sub_b   <= '0;
      cur_n   <= '0;
      ret_val <= '0;
    end else begin
      done  <= 1'b0;
      sub_a <= '0;
      sub_b <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_n <= n_in;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_CALL;
          end
        end
        S_CALL: begin
          if (cur_n < N_W'(2)) begin
            ret_val <= RES_W'(cur_n);
            state   <= S_RET;
          end else if (full) begin
            err     <= 1'b1;
            ret_val <= '0;
            result  <= '0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            sub_a <= cur_n;
            sub_b <= 3'd1;
            state <= S_SUB1;
          end
        end
        S_SUB1, S_SUB2: begin
          cur_n <= sub_s;
          state <= S_CALL;
        end
        S_RET: begin
          if (empty) begin
            result <= ret_val;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (!top_ph) begin
            cur_n <= top_n;
            sub_a <= top_n;
            sub_b <= 3'd2;
            state <= S_SUB2;
          end else begin
            ret_val <= sum;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) assert (sp < SP_W'(DEPTH));
  end

endmodule

// File: tb/tb_fib_controller.sv
// Directed bench for fib_controller: latency, results, subtractor drive, busy
// start filtering, async reset and stack overflow on a shallow build.
module tb_fib_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start, start2;
  logic [2:0] n_in, n_in2;
  logic       busy, done, err, busy2, done2, err2;
  logic [7:0] result, result2;
  logic [2:0] sub_a, sub_b, sub_s, sub_a2, sub_b2, sub_s2;

  int vectors = 0;
  int miscompares = 0;
  int peak = 0;

  always #5 clk = ~clk;

  assign sub_s  = sub_a - sub_b;
  assign sub_s2 = sub_a2 - sub_b2;

  fib_controller #(.DEPTH(8), .RES_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .busy(busy), .done(done),
    .result(result), .err(err), .sub_a(sub_a), .sub_b(sub_b), .sub_s(sub_s)
  );

  fib_controller #(.DEPTH(2), .RES_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .n_in(n_in2), .busy(busy2), .done(done2),
    .result(result2), .err(err2), .sub_a(sub_a2), .sub_b(sub_b2), .sub_s(sub_s2)
  );

  // Start one computation and return the cycle in which done was seen (0 = timeout).
  task automatic run(input bit sel, input logic [2:0] n, output int lat,
                     output logic [7:0] res, output logic e);
    @(negedge clk);
    if (sel) begin start2 = 1'b1; n_in2 = n; end
    else     begin start  = 1'b1; n_in  = n; end
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    lat = 0; peak = 0;
    for (int c = 1; c <= 400; c++) begin
      if (!sel && int'(dut.u_stack.sp) > peak) peak = int'(dut.u_stack.sp);
      if ((sel ? done2 : done) === 1'b1) begin lat = c; break; end
      @(negedge clk);
    end
    res = sel ? result2 : result;
    e   = sel ? err2 : err;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] res; logic e;
    vectors++;
    if ({busy, done, err, result, sub_a, sub_b} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected all zero", {busy, done, err, result, sub_a, sub_b});
    end
    vectors++;
    if ({busy2, done2, err2, result2} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs2: got %b expected all zero", {busy2, done2, err2, result2});
    end
    @(negedge clk); rst = 1'b0;
    run(1'b0, 3'd0, lat, res, e);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL n0_latency: got %0d expected 3", lat); end
    vectors++;
    if (res !== 8'd0) begin miscompares++; $display("FAIL n0_result: got %0d expected 0", res); end
  endtask

  task automatic test_n1();
    int lat; logic [7:0] res; logic e;
    run(1'b0, 3'd1, lat, res, e);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL n1_latency: got %0d expected 3", lat); end
    vectors++;
    if (res !== 8'd1) begin miscompares++; $display("FAIL n1_result: got %0d expected 1", res); end
  endtask

  task automatic test_n2();
    int lat = 0;
    logic [5:0] s2 = '0, s3 = '1, s5 = '0;
    @(negedge clk); start = 1'b1; n_in = 3'd2;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) s2 = {sub_a, sub_b};
      if (c == 3) s3 = {sub_a, sub_b};
      if (c == 5) s5 = {sub_a, sub_b};
      if (done === 1'b1) begin lat = c; break; end
      @(negedge clk);
    end
    vectors++;
    if (s2 !== {3'd2, 3'd1}) begin miscompares++; $display("FAIL n2_sub_c2: got a/b %0d/%0d expected 2/1", s2[5:3], s2[2:0]); end
    vectors++;
    if (s3 !== 6'd0) begin miscompares++; $display("FAIL n2_sub_c3: got a/b %0d/%0d expected 0/0", s3[5:3], s3[2:0]); end
    vectors++;
    if (s5 !== {3'd2, 3'd2}) begin miscompares++; $display("FAIL n2_sub_c5: got a/b %0d/%0d expected 2/2", s5[5:3], s5[2:0]); end
    vectors++;
    if (lat !== 9) begin miscompares++; $display("FAIL n2_latency: got %0d expected 9", lat); end
    vectors++;
    if (result !== 8'd1) begin miscompares++; $display("FAIL n2_result: got %0d expected 1", result); end
  endtask

  task automatic test_fib_values();
    int lat; logic [7:0] res; logic e;
    run(1'b0, 3'd5, lat, res, e);
    vectors++;
    if (res !== 8'd5) begin miscompares++; $display("FAIL n5_result: got %0d expected 5", res); end
    vectors++;
    if (lat !== 45) begin miscompares++; $display("FAIL n5_latency: got %0d expected 45", lat); end
    run(1'b0, 3'd7, lat, res, e);
    vectors++;
    if (res !== 8'd13) begin miscompares++; $display("FAIL n7_result: got %0d expected 13", res); end
    vectors++;
    if (lat !== 123) begin miscompares++; $display("FAIL n7_latency: got %0d expected 123", lat); end
    vectors++;
    if (peak !== 6) begin miscompares++; $display("FAIL n7_peak_sp: got %0d expected 6", peak); end
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL n7_err: got %b expected 0", e); end
  endtask

  task automatic test_busy_ignore();
    int lat = 0;
    @(negedge clk); start = 1'b1; n_in = 3'd5;
    @(negedge clk);
    for (int c = 1; c <= 200; c++) begin
      if (done === 1'b1) begin lat = c; break; end
      start = c[0]; n_in = 3'd3;
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (lat !== 45) begin miscompares++; $display("FAIL busy_ignore_latency: got %0d expected 45", lat); end
    vectors++;
    if (result !== 8'd5) begin miscompares++; $display("FAIL busy_ignore_result: got %0d expected 5", result); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] res; logic e;
    run(1'b0, 3'd3, lat, res, e);
    vectors++;
    if (res !== 8'd2 || lat !== 15) begin
      miscompares++; $display("FAIL b2b_first: got result %0d latency %0d expected 2 / 15", res, lat);
    end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_in_done: got %b expected 1", busy); end
    run(1'b0, 3'd6, lat, res, e);
    vectors++;
    if (res !== 8'd8 || lat !== 75) begin
      miscompares++; $display("FAIL b2b_second: got result %0d latency %0d expected 8 / 75", res, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] res; logic e;
    @(negedge clk); start = 1'b1; n_in = 3'd7;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || result !== 8'd8) begin
      miscompares++; $display("FAIL mid_pre_reset: got busy %b result %0d expected 1 / 8", busy, result);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, err, result, sub_a, sub_b} !== 17'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %b expected all zero", {busy, done, err, result, sub_a, sub_b});
    end
    vectors++;
    if (dut.u_stack.sp !== 4'd0) begin miscompares++; $display("FAIL mid_reset_sp: got %0d expected 0", dut.u_stack.sp); end
    @(negedge clk); rst = 1'b0;
    run(1'b0, 3'd4, lat, res, e);
    vectors++;
    if (res !== 8'd3 || lat !== 27) begin
      miscompares++; $display("FAIL post_reset_n4: got result %0d latency %0d expected 3 / 27", res, lat);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [7:0] res; logic e;
    run(1'b1, 3'd3, lat, res, e);
    vectors++;
    if (res !== 8'd2 || e !== 1'b0 || lat !== 15) begin
      miscompares++; $display("FAIL d2_n3: got result %0d err %b latency %0d expected 2 / 0 / 15", res, e, lat);
    end
    run(1'b1, 3'd5, lat, res, e);
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b expected 1", e); end
    vectors++;
    if (res !== 8'd0) begin miscompares++; $display("FAIL ovf_result: got %0d expected 0", res); end
    vectors++;
    if (lat !== 6) begin miscompares++; $display("FAIL ovf_latency: got %0d expected 6", lat); end
    @(negedge clk);
    vectors++;
    if (err2 !== 1'b1 || busy2 !== 1'b0) begin
      miscompares++; $display("FAIL ovf_sticky: got err %b busy %b expected 1 / 0", err2, busy2);
    end
    run(1'b1, 3'd1, lat, res, e);
    vectors++;
    if (e !== 1'b0 || res !== 8'd1 || lat !== 3) begin
      miscompares++; $display("FAIL ovf_clear: got err %b result %0d latency %0d expected 0 / 1 / 3", e, res, lat);
    end
  endtask

  initial begin
    start = 1'b0; start2 = 1'b0; n_in = '0; n_in2 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_n1();
    test_n2();
    test_fib_values();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fib_controller.md
# fib_controller

Sequencing controller for the recursive Fibonacci datapath: computes fib(n) for a 3-bit n by explicit recursion over an internal frame stack. It is the only driver of the shared 3-bit `subtractor`, which it uses to form n-1 and n-2. It accumulates partial sums in an internal adder and reports the result with a start/done handshake.

## Interface
- `DEPTH`, 8: number of stack frames (must be at least 6 for n ≤ 7).
- `RES_W`, 8: result width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin computation; sampled only in IDLE.
- `n_in` in 3: operand, captured when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out RES_W: fib(n_in); holds until the next accepted `start` or reset.
- `err` out 1: sticky stack overflow flag; cleared on an accepted `start` or reset.
- `sub_a` out 3: subtractor minuend.
- `sub_b` out 3: subtractor subtrahend.
- `sub_s` in 3: subtractor difference, combinational from `sub_a` and `sub_b`.

## Operation
- Registers:
  - `cur_n[2:0]`
  - `ret_val[RES_W-1:0]`
  - `sp` (0..DEPTH)
  - stack of frames `{n[2:0], phase, acc[RES_W-1:0]}`
- States: IDLE, CALL, SUB1, SUB2, RET, DONE.
- IDLE: on `start`, capture `cur_n<=n_in`, set `sp<=0`, `err<=0`, go to CALL.
- CALL:
  - If `cur_n<2`: `ret_val<=cur_n` (zero-extended), go to RET.
  - Otherwise: push `{cur_n,0,0}` and go to SUB1.
  - If the push finds `sp==DEPTH`: set `err<=1`, `ret_val<=0`, go to DONE; do not push.
- SUB1: drive `sub_a=cur_n`, `sub_b=1`; `cur_n<=sub_s`; go to CALL.
- SUB2: drive `sub_a=cur_n`, `sub_b=2`; `cur_n<=sub_s`; go to CALL.
- RET:
  - If `sp==0`: `result<=ret_val`, go to DONE.
  - Else if top `phase==0`: top `acc<=ret_val`, top `phase<=1`, `cur_n<=top.n`, go to SUB2.
  - Else (`phase==1`): `ret_val<=top.acc+ret_val` (mod 2^RES_W), pop, remain in RET.
- DONE: `done=1` for this cycle only; go to IDLE.
- `sub_a` and `sub_b` are 0 outside SUB1/SUB2. The controller never underflows because n ≥ 2 whenever a subtraction is issued.
- `start` is ignored while `busy`. `start` is accepted in IDLE in the cycle after DONE.

## Timing
- Reset values:
  - state IDLE
  - `busy=0`, `done=0`, `err=0`
  - `result=0`, `sub_a=0`, `sub_b=0`
  - `sp=0`, `cur_n=0`, `ret_val=0`
- Cycle numbering: cycle 0 is the edge that samples `start`.
- n=0 or n=1: `done` is high in cycle 3 (CALL, RET, DONE).
- n=2: `done` is high in cycle 9 (CALL, SUB1, CALL, RET, SUB2, CALL, RET, RET, DONE).
- Each CALL costs 1 cycle, each SUB 1 cycle, and each RET step 1 cycle. Latency is deterministic in n.
- Maximum stack occupancy is n-1 frames (6 for n=7).
- Reset mid-operation: immediate return to IDLE with reset values. The stack contents are don't-care and are never read with `sp==0`.
- The subtractor is combinational: `sub_s` is captured at the end of the same SUB cycle.

## Structure
- Shared header `fib_pkg`:
  - state localparams (one-hot or binary, fixed encoding)
  - `N_W=3`
  - frame field widths and frame packing offsets
- Sub-module `fib_stack`: a LIFO of DEPTH frames with ports:
  - `clk`, `rst`
  - `push`, `pop`, `wr_top` (with frame data)
  - `top`, `sp`, `full`, `empty`
- Push and pop are never simultaneous. `wr_top` is never concurrent with push or pop.
- The top controller instantiates `fib_stack` and the RES_W adder. It connects `sub_a`/`sub_b`/`sub_s` to an external `subtractor` instance.

## Test plan
- Reset, then idle: assert `rst` mid-cycle → all outputs 0 immediately, with no `clk` edge needed; `start` with `n_in=0` → `done` in cycle 3, `result=0`.
- `n_in=1` → `result=1`, `done` in cycle 3. `n_in=2` → `result=1`, `done` in cycle 9; check `sub_a/sub_b` = 2/1 in cycle 2 and 2/2 in cycle 5.
- `n_in=5` → `result=5`. `n_in=6` → `result=8`. `n_in=7` → `result=13`, peak `sp=6`, `err=0`.
- `start` pulsed repeatedly while busy with `n_in=3` → ignored; result is fib of the original n. Back-to-back `start` in the cycle after `done` is accepted.
- `rst` asserted mid-computation for n=7 → IDLE with zeroed outputs. A following `start` with `n_in=4` → `result=3`.
- `DEPTH=2` build with `n_in=5` → `err=1`, `done` pulses, `result=0`. The next `start` clears `err`.
